ber_checker: RTL and testbench



---
 rtl/ber_checker.sv | 200 ++++++++++++++++++++
 tb/tb_ber_checker.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ber_checker.sv
// rtl/ber_checker.sv - receive-side BER checker with reference FIFO; optional first-error capture under BER_CAPTURE_EN
module ber_checker #(
  parameter int WIDTH      = 12,
  parameter int CNT_W      = 50,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_word,
  input  logic             rx_valid,
  input  logic [WIDTH-1:0] rx_word,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      window,
  output logic [CNT_W-1:0] Errors,
  output logic [CNT_W-1:0] Words,
  output logic             Error_flag,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             unf
`ifdef BER_CAPTURE_EN
  , output logic [31:0]      first_err_idx
  , output logic [WIDTH-1:0] first_err_diff
  , output logic             first_err_vld
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int N_W   = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]      CNT_ONE = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = DEPTH[DEPTH_LOG2:0];

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [WIDTH-1:0]       mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]    count_q, count_d;
  logic [CNT_W-1:0]       errors_q, errors_d, words_q, words_d;
  logic                   flag_q, flag_d, busy_q, busy_d, done_q, done_d;
  logic                   ovf_q, ovf_d, unf_q, unf_d;
`ifdef BER_CAPTURE_EN
  logic [31:0]            cap_idx_q, cap_idx_d;
  logic [WIDTH-1:0]       cap_diff_q, cap_diff_d;
  logic                   cap_vld_q, cap_vld_d;
`endif

  logic                   in_run, empty, full, push_req, do_push, do_cmp;
  logic [WIDTH-1:0]       diff;
  logic [N_W-1:0]         pop_n;
  logic [CNT_W:0]         err_sum;
  logic [CNT_W-1:0]       errors_sat, words_sat;
  logic                   window_hit;

  // Popcount of the XOR between the FIFO head and the received word
  always_comb begin
    diff  = mem_q[rd_ptr_q] ^ rx_word;
    pop_n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_n = pop_n + {{(N_W-1){1'b0}}, diff[i]};
    end
  end

  // Next-state, FIFO and counter update; start overrides everything else
  always_comb begin
    in_run     = (state_q == S_RUN);
    empty      = (count_q == '0);
    full       = (count_q == FULL_CNT);
    do_cmp     = in_run && !start && rx_valid && !empty;
    push_req   = in_run && !start && tx_valid;
    do_push    = push_req && (!full || do_cmp);
    err_sum    = {1'b0, errors_q} + {{(CNT_W+1-N_W){1'b0}}, pop_n};
    errors_sat = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    words_sat  = (&words_q) ? words_q : words_q + CNT_ONE;
    window_hit = (window != 32'd0) &&
                 ({32'd0, words_sat} >= {{CNT_W{1'b0}}, window});

    state_d  = state_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    errors_d = errors_q;
    words_d  = words_q;
    flag_d   = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
`ifdef BER_CAPTURE_EN
    cap_idx_d  = cap_idx_q;
    cap_diff_d = cap_diff_q;
    cap_vld_d  = cap_vld_q;
`endif

    if (start) begin
      state_d  = S_RUN;
      errors_d = '0;
      words_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
`ifdef BER_CAPTURE_EN
      cap_idx_d  = '0;
      cap_diff_d = '0;
      cap_vld_d  = 1'b0;
`endif
    end else if (in_run) begin
      if (do_push) begin
        mem_d[wr_ptr_q] = tx_word;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (do_cmp) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        errors_d = errors_sat;
        words_d  = words_sat;
        flag_d   = (pop_n != '0);
`ifdef BER_CAPTURE_EN
        if ((pop_n != '0) && !cap_vld_q) begin
          cap_idx_d  = 32'(words_q);
          cap_diff_d = diff;
          cap_vld_d  = 1'b1;
        end
`endif
      end
      count_d = count_q + {{DEPTH_LOG2{1'b0}}, do_push} - {{DEPTH_LOG2{1'b0}}, do_cmp};
      if (push_req && full && !do_cmp) ovf_d = 1'b1;
      if (rx_valid && empty) unf_d = 1'b1;
      if (stop || (do_cmp && window_hit)) state_d = S_DONE;
    end

    // Outside RUN the reference FIFO is kept empty
    if (state_d != S_RUN) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // All state registers, cleared asynchronously by reset
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      errors_q <= '0;
      words_q  <= '0;
      flag_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
`ifdef BER_CAPTURE_EN
      cap_idx_q  <= '0;
      cap_diff_q <= '0;
      cap_vld_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      errors_q <= errors_d;
      words_q  <= words_d;
      flag_q   <= flag_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
`ifdef BER_CAPTURE_EN
      cap_idx_q  <= cap_idx_d;
      cap_diff_q <= cap_diff_d;
      cap_vld_q  <= cap_vld_d;
`endif
    end
  end

  assign Errors     = errors_q;
  assign Words      = words_q;
  assign Error_flag = flag_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ovf        = ovf_q;
  assign unf        = unf_q;
`ifdef BER_CAPTURE_EN
  assign first_err_idx  = cap_idx_q;
  assign first_err_diff = cap_diff_q;
  assign first_err_vld  = cap_vld_q;
`endif

endmodule

// File: tb/tb_ber_checker.sv
// tb/tb_ber_checker.sv - scoreboard bench for ber_checker
module tb_ber_checker;

  localparam int WIDTH      = 12;
  localparam int CNT_W      = 8;
  localparam int DEPTH_LOG2 = 3;

  logic             CLK = 1'b0;
  logic             reset = 1'b1;
  logic             tx_valid = 1'b0, rx_valid = 1'b0, start = 1'b0, stop = 1'b0;
  logic [WIDTH-1:0] tx_word = '0, rx_word = '0;
  logic [31:0]      window = '0;
  logic [CNT_W-1:0] Errors, Words;
  logic             Error_flag, busy, done, ovf, unf;
`ifdef BER_CAPTURE_EN
  logic [31:0]      first_err_idx;
  logic [WIDTH-1:0] first_err_diff;
  logic             first_err_vld;
`endif

  always #5 CLK = ~CLK;

  ber_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .CLK(CLK), .reset(reset),
    .tx_valid(tx_valid), .tx_word(tx_word),
    .rx_valid(rx_valid), .rx_word(rx_word),
    .start(start), .stop(stop), .window(window),
    .Errors(Errors), .Words(Words), .Error_flag(Error_flag),
    .busy(busy), .done(done), .ovf(ovf), .unf(unf)
`ifdef BER_CAPTURE_EN
    , .first_err_idx(first_err_idx), .first_err_diff(first_err_diff), .first_err_vld(first_err_vld)
`endif
  );

  logic [2*CNT_W+4:0] outs;
  assign outs = {Errors, Words, Error_flag, busy, done, ovf, unf};

  typedef struct {
    int                 cyc;
    string              name;
    logic [2*CNT_W+4:0] v;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  int   cyc_cnt  = 0;

  always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: actual=%h required=%h (Errors,Words,flag,busy,done,ovf,unf)", name, act, req);
    end
  endtask

  // Monitor: compares every expectation due at this cycle
  always @(negedge CLK) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      e = q.pop_front();
      check(e.name, 64'(outs), 64'(e.v));
    end
  end

  task automatic want(input string name, input int e, input int w,
                      input logic f, input logic b, input logic d, input logic o, input logic u);
    exp_t x;
    x.cyc  = cyc_cnt + 1;
    x.name = name;
    x.v    = {8'(e), 8'(w), f, b, d, o, u};
    q.push_back(x);
  endtask

  task automatic tick(input logic tv, input logic [WIDTH-1:0] tw, input logic rv,
                      input logic [WIDTH-1:0] rw, input logic st, input logic sp);
    tx_valid = tv; tx_word = tw; rx_valid = rv; rx_word = rw; start = st; stop = sp;
    @(negedge CLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    @(negedge CLK);
    @(negedge CLK);
    check("reset_outs", 64'(outs), 64'd0);
    reset = 1'b0;
    @(negedge CLK);
    want("idle_stop", 0, 0, 0, 0, 0, 0, 0); tick(0, 0, 0, 0, 0, 1);

    // Identical stream, window of 10
    window = 10;
    want("t1_start", 0, 0, 0, 1, 0, 0, 0); tick(0, 0, 0, 0, 1, 0);
    for (int j = 0; j < 12; j++) begin
      w = (j >= 2) ? j - 1 : 0;
      want("t1_stream", 0, w, 0, (w < 10), (w == 10), 0, 0);
      tick(j < 10, 12'h66A, j >= 2, 12'h66A, 0, 0);
    end
    want("t1_done", 0, 10, 0, 0, 1, 0, 0); tick(0, 0, 0, 0, 0, 0);

    // 1-bit and 12-bit errors, unlimited window
    window = 0;
    want("t2_start", 0, 0, 0, 1, 0, 0, 0);   tick(0, 0, 0, 0, 1, 0);
    want("t2_push", 0, 0, 0, 1, 0, 0, 0);    tick(1, 12'h66A, 0, 0, 0, 0);
    want("t2_err1", 1, 1, 1, 1, 0, 0, 0);    tick(1, 12'hE6A, 1, 12'h66B, 0, 0);
    want("t2_err12", 13, 2, 1, 1, 0, 0, 0);  tick(0, 0, 1, 12'h195, 0, 0);
    want("t2_idle", 13, 2, 0, 1, 0, 0, 0);   tick(0, 0, 0, 0, 0, 0);
    want("t2_stop", 13, 2, 0, 0, 1, 0, 0);   tick(0, 0, 0, 0, 0, 1);
    want("t2_stop_done", 13, 2, 0, 0, 1, 0, 0); tick(0, 0, 0, 0, 0, 1);

    // Start priority, overflow, full push+pop, underflow
    want("t3_start_prio", 0, 0, 0, 1, 0, 0, 0); tick(1, 12'h0FF, 1, 12'h0FF, 1, 1);
    for (int k = 1; k <= 9; k++) begin
      want("t3_fill", 0, 0, 0, 1, 0, (k == 9), 0); tick(1, 12'(k), 0, 0, 0, 0);
    end
    want("t3_full_pushpop", 0, 1, 0, 1, 0, 1, 0); tick(1, 12'h0AA, 1, 12'h001, 0, 0);
    for (int k = 2; k <= 8; k++) begin
      want("t3_drain", 0, k, 0, 1, 0, 1, 0); tick(0, 0, 1, 12'(k), 0, 0);
    end
    want("t3_last", 0, 9, 0, 1, 0, 1, 0);   tick(0, 0, 1, 12'h0AA, 0, 0);
    want("t3_unf", 0, 9, 0, 1, 0, 1, 1);    tick(0, 0, 1, 12'h0AA, 0, 0);
    want("t3_flush", 0, 0, 0, 1, 0, 0, 0);  tick(0, 0, 0, 0, 1, 0);
    want("t3_unf_tx", 0, 0, 0, 1, 0, 0, 1); tick(1, 12'h123, 1, 12'h123, 0, 0);
    want("t3_after_unf", 0, 1, 0, 1, 0, 0, 1); tick(0, 0, 1, 12'h123, 0, 0);
    want("t3_push", 0, 1, 0, 1, 0, 0, 1);   tick(1, 12'h700, 0, 0, 0, 0);
    want("t3_stop_cmp", 3, 2, 1, 0, 1, 0, 1); tick(0, 0, 1, 12'h000, 0, 1);

    // Saturation of Errors, then window lowered below Words
    want("t4_start", 0, 0, 0, 1, 0, 0, 0); tick(0, 0, 0, 0, 1, 0);
    want("t4_first", 0, 0, 0, 1, 0, 0, 0); tick(1, 12'hFFF, 0, 0, 0, 0);
    for (int j = 1; j <= 23; j++) begin
      want("t4_sat", (12 * j > 255) ? 255 : 12 * j, j, 1, 1, 0, 0, 0);
      tick(1, 12'hFFF, 1, 12'h000, 0, 0);
    end
    window = 5;
    want("t4_win_low", 255, 24, 1, 0, 1, 0, 0); tick(0, 0, 1, 12'h000, 0, 0);

    // Asynchronous reset mid-run, then a clean restart
    window = 0;
    want("t5_start", 0, 0, 0, 1, 0, 0, 0); tick(0, 0, 0, 0, 1, 0);
    want("t5_push", 0, 0, 0, 1, 0, 0, 0);  tick(1, 12'h01F, 0, 0, 0, 0);
    want("t5_err5", 5, 1, 1, 1, 0, 0, 0);  tick(0, 0, 1, 12'h000, 0, 0);
    #2 reset = 1'b1;
    #1 check("t5_async_reset", 64'(outs), 64'd0);
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    want("t5_restart", 0, 0, 0, 1, 0, 0, 0); tick(0, 0, 0, 0, 1, 0);
    want("t5_push2", 0, 0, 0, 1, 0, 0, 0);   tick(1, 12'h5A5, 0, 0, 0, 0);
    want("t5_clean", 1, 1, 1, 1, 0, 0, 0);   tick(0, 0, 1, 12'h5A4, 0, 0);

`ifdef BER_CAPTURE_EN
    want("t6_start", 0, 0, 0, 1, 0, 0, 0); tick(0, 0, 0, 0, 1, 0);
    want("t6_push", 0, 0, 0, 1, 0, 0, 0);  tick(1, 12'h000, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      want("t6_stream", (i >= 7) ? 4 : ((i >= 3) ? 1 : 0), i + 1, (i == 3) || (i == 7), 1, 0, 0, 0);
      tick(i < 7, 12'h000, 1, (i == 3) ? 12'h010 : ((i == 7) ? 12'h301 : 12'h000), 0, 0);
    end
    check("t6_capture", 64'({first_err_idx, first_err_diff, first_err_vld}), 64'({32'd3, 12'h010, 1'b1}));
    want("t6_restart", 0, 0, 0, 1, 0, 0, 0); tick(0, 0, 0, 0, 1, 0);
    check("t6_cleared", 64'({first_err_idx, first_err_diff, first_err_vld}), 64'd0);
`endif

    @(negedge CLK);
    @(negedge CLK);
    n_checks++;
    if (q.size() != 0) begin
      n_errs++;
      $display("FAIL pending_expectations: actual=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
